soc_uart: RTL and testbench

- Memory-mapped 8N1 UART peripheral on the data-side bus, downstream of the memory arbiter.
- Sits alongside the GPIO and RTC slaves and uses the same per-slave interface: address, wdata, write strobe, rdata, ready.
- TX path: FIFO feeding a baud-rate serialiser.
- RX path (optional): synchroniser, deserialiser and FIFO.

---
 rtl/soc_uart_pkg.sv | 27 ++
 rtl/soc_uart_fifo.sv | 55 +++++
 rtl/soc_uart.sv | 235 +++++++++++++++++++++++
 tb/tb_soc_uart.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/soc_uart_pkg.sv
// rtl/soc_uart_pkg.sv - shared register map, status bits, FSM encodings for soc_uart
package soc_uart_pkg;

   localparam logic [3:0] ADDR_TXDATA  = 4'h0;
   localparam logic [3:0] ADDR_STATUS  = 4'h4;
   localparam logic [3:0] ADDR_BAUDDIV = 4'h8;
   localparam logic [3:0] ADDR_RXDATA  = 4'hC;

   localparam int ST_TX_FULL      = 0;
   localparam int ST_TX_EMPTY     = 1;
   localparam int ST_TX_BUSY      = 2;
   localparam int ST_RX_VALID     = 3;
   localparam int ST_RX_OVERRUN   = 4;
   localparam int ST_TX_DROP      = 5;
   localparam int ST_RX_FRAME_ERR = 6;

   localparam logic [15:0] MIN_DIV = 16'd3;

   typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

   // Dividers below MIN_DIV leave too few clocks per bit for mid-bit sampling
   function automatic logic [15:0] clamp_div(input logic [15:0] div);
      return (div < MIN_DIV) ? MIN_DIV : div;
   endfunction

endpackage

// File: rtl/soc_uart_fifo.sv
// rtl/soc_uart_fifo.sv - synchronous FIFO with registered read data
module soc_uart_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr, rd_ptr;
   logic [AW:0]      count;
   logic             do_push, do_pop;

   assign full    = (count == FULL_CNT);
   assign empty   = (count == '0);
   assign do_pop  = pop && !empty;
   // A pop frees the slot in the same cycle, so a push into a full FIFO is kept then
   assign do_push = push && (!full || do_pop);

   // Storage array; contents are only ever read behind the occupancy count
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

   // Pointers, occupancy and read-data register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
         rd_data <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop) begin
            rd_ptr  <= rd_ptr + AW'(1);
            rd_data <= mem[rd_ptr];
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/soc_uart.sv
// rtl/soc_uart.sv - memory-mapped 8N1 UART; RX path built only with SOC_UART_RX_EN
module soc_uart
   import soc_uart_pkg::*;
#(
   parameter int          FIFO_DEPTH  = 4,
   parameter logic [15:0] DEFAULT_DIV = 16'd68
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        uart_sel,
   input  logic        uart_we,
   input  logic [3:0]  uart_addr,
   input  logic [31:0] uart_wdata,
   output logic [31:0] uart_rdata,
   output logic        uart_ready,
   output logic        uart_tx,
   input  logic        uart_rx
);
   logic        wr_en, rd_en, status_wr, tx_push, tx_pop, tx_full, tx_empty;
   logic        tx_drop, tx_tick, tx_line, rx_rd_hit;
   logic        rx_valid, rx_overrun, rx_frame_err, rx_pop;
   logic [7:0]  tx_byte, rx_byte;
   logic [15:0] baud_div, tx_div, tx_cnt;
   logic [2:0]  tx_bit;
   logic [31:0] rdata_q, rdata_d;
   tx_state_t   tx_state, tx_next;
   logic        unused_in;

   assign unused_in = ^{uart_wdata[31:16], uart_rx};
   assign wr_en     = uart_sel & uart_we;
   assign rd_en     = uart_sel & ~uart_we;
   assign status_wr = wr_en && (uart_addr == ADDR_STATUS);
   assign tx_push   = wr_en && (uart_addr == ADDR_TXDATA);

   soc_uart_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
      .clk(clk), .rst_n(rst), .push(tx_push), .push_data(uart_wdata[7:0]),
      .pop(tx_pop), .rd_data(tx_byte), .full(tx_full), .empty(tx_empty)
   );

   // Divider register and the TX drop flag (W1C)
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         baud_div <= DEFAULT_DIV;
         tx_drop  <= 1'b0;
      end else begin
         if (wr_en && uart_addr == ADDR_BAUDDIV) baud_div <= clamp_div(uart_wdata[15:0]);
         if (tx_push && tx_full && !tx_pop) tx_drop <= 1'b1;
         else if (status_wr && uart_wdata[ST_TX_DROP]) tx_drop <= 1'b0;
      end
   end

   // Read mux for the registers whose value is known in the access cycle
   always_comb begin
      rdata_d = 32'd0;
      case (uart_addr)
         ADDR_STATUS: begin
            rdata_d[ST_TX_FULL]      = tx_full;
            rdata_d[ST_TX_EMPTY]     = tx_empty;
            rdata_d[ST_TX_BUSY]      = (tx_state != TX_IDLE);
            rdata_d[ST_RX_VALID]     = rx_valid;
            rdata_d[ST_RX_OVERRUN]   = rx_overrun;
            rdata_d[ST_TX_DROP]      = tx_drop;
            rdata_d[ST_RX_FRAME_ERR] = rx_frame_err;
         end
         ADDR_BAUDDIV: rdata_d[15:0] = baud_div;
         default: ;
      endcase
   end

   // One-cycle bus response; an RXDATA pop shows the FIFO's freshly registered byte
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         uart_ready <= 1'b0;
         rdata_q    <= 32'd0;
         rx_rd_hit  <= 1'b0;
      end else begin
         uart_ready <= uart_sel;
         rdata_q    <= rd_en ? rdata_d : 32'd0;
         rx_rd_hit  <= rx_pop;
      end
   end
   assign uart_rdata = rx_rd_hit ? {24'd0, rx_byte} : rdata_q;

   assign tx_tick = (tx_cnt == tx_div);

   // TX state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) tx_state <= TX_IDLE;
      else      tx_state <= tx_next;
   end

   // TX next state; STOP chains straight into START when more bytes wait
   always_comb begin
      tx_next = tx_state;
      case (tx_state)
         TX_IDLE:  if (!tx_empty) tx_next = TX_START;
         TX_START: if (tx_tick) tx_next = TX_DATA;
         TX_DATA:  if (tx_tick && tx_bit == 3'd7) tx_next = TX_STOP;
         TX_STOP:  if (tx_tick) tx_next = tx_empty ? TX_IDLE : TX_START;
         default:  tx_next = TX_IDLE;
      endcase
   end

   // TX outputs: FIFO pop on frame launch and the serial line level
   always_comb begin
      tx_pop  = 1'b0;
      tx_line = 1'b1;
      case (tx_state)
         TX_IDLE:  tx_pop = !tx_empty;
         TX_START: tx_line = 1'b0;
         TX_DATA:  tx_line = tx_byte[tx_bit];
         TX_STOP:  tx_pop = tx_tick && !tx_empty;
         default: ;
      endcase
   end

   // TX bit timing; the divider is sampled only at frame start
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         uart_tx <= 1'b1;
         tx_div  <= DEFAULT_DIV;
         tx_cnt  <= 16'd0;
         tx_bit  <= 3'd0;
      end else begin
         uart_tx <= tx_line;
         if (tx_next == TX_START && tx_state != TX_START) begin
            tx_div <= baud_div;
            tx_cnt <= 16'd0;
         end else if (tx_state != TX_IDLE) begin
            tx_cnt <= tx_tick ? 16'd0 : tx_cnt + 16'd1;
         end
         if (tx_state == TX_START)            tx_bit <= 3'd0;
         else if (tx_state == TX_DATA && tx_tick) tx_bit <= tx_bit + 3'd1;
      end
   end

`ifdef SOC_UART_RX_EN
   rx_state_t   rx_state, rx_next;
   logic        rx_s1, rx_s2, rx_s3, rx_fall, rx_tick, rx_push, rx_full, rx_empty;
   logic        rx_set_ovr, rx_set_ferr;
   logic [15:0] rx_div, rx_cnt, rx_lim;
   logic [2:0]  rx_bit;
   logic [7:0]  rx_shift;

   assign rx_fall  = rx_s3 & ~rx_s2;
   // START waits (DIV+1)>>1 clocks after the edge; later bits wait DIV+1
   assign rx_lim   = (rx_state == RX_START) ? ((rx_div - 16'd1) >> 1) : rx_div;
   assign rx_tick  = (rx_cnt == rx_lim);
   assign rx_valid = !rx_empty;
   assign rx_pop   = rd_en && (uart_addr == ADDR_RXDATA) && rx_valid;

   soc_uart_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
      .clk(clk), .rst_n(rst), .push(rx_push), .push_data(rx_shift),
      .pop(rx_pop), .rd_data(rx_byte), .full(rx_full), .empty(rx_empty)
   );

   // Two-flop synchroniser plus a delay stage for falling-edge detection
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) {rx_s1, rx_s2, rx_s3} <= 3'b111;
      else      {rx_s1, rx_s2, rx_s3} <= {uart_rx, rx_s1, rx_s2};
   end

   // RX state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) rx_state <= RX_IDLE;
      else      rx_state <= rx_next;
   end

   // RX next state; a high line at mid-start is treated as a glitch
   always_comb begin
      rx_next = rx_state;
      case (rx_state)
         RX_IDLE:  if (rx_fall) rx_next = RX_START;
         RX_START: if (rx_tick) rx_next = rx_s2 ? RX_IDLE : RX_DATA;
         RX_DATA:  if (rx_tick && rx_bit == 3'd7) rx_next = RX_STOP;
         RX_STOP:  if (rx_tick) rx_next = RX_IDLE;
         default:  rx_next = RX_IDLE;
      endcase
   end

   // RX outputs at the stop-bit sample: push a good byte or flag the error
   always_comb begin
      rx_push     = 1'b0;
      rx_set_ferr = 1'b0;
      rx_set_ovr  = 1'b0;
      if (rx_state == RX_STOP && rx_tick) begin
         rx_push     = rx_s2;
         rx_set_ferr = !rx_s2;
         rx_set_ovr  = rx_s2 && rx_full && !rx_pop;
      end
   end

   // RX bit timing and LSB-first shift register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rx_div   <= DEFAULT_DIV;
         rx_cnt   <= 16'd0;
         rx_bit   <= 3'd0;
         rx_shift <= 8'd0;
      end else begin
         if (rx_state == RX_IDLE) begin
            rx_div <= baud_div;
            rx_cnt <= 16'd0;
            rx_bit <= 3'd0;
         end else begin
            rx_cnt <= rx_tick ? 16'd0 : rx_cnt + 16'd1;
         end
         if (rx_state == RX_DATA && rx_tick) begin
            rx_shift <= {rx_s2, rx_shift[7:1]};
            rx_bit   <= rx_bit + 3'd1;
         end
      end
   end

   // RX sticky flags, cleared by writing 1 to their STATUS bits
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rx_overrun   <= 1'b0;
         rx_frame_err <= 1'b0;
      end else begin
         if (rx_set_ovr) rx_overrun <= 1'b1;
         else if (status_wr && uart_wdata[ST_RX_OVERRUN]) rx_overrun <= 1'b0;
         if (rx_set_ferr) rx_frame_err <= 1'b1;
         else if (status_wr && uart_wdata[ST_RX_FRAME_ERR]) rx_frame_err <= 1'b0;
      end
   end
`else
   assign rx_valid     = 1'b0;
   assign rx_overrun   = 1'b0;
   assign rx_frame_err = 1'b0;
   assign rx_byte      = 8'd0;
   assign rx_pop       = 1'b0;
`endif

endmodule

// File: tb/tb_soc_uart.sv
// tb/tb_soc_uart.sv - self-checking bench for soc_uart (RX steps under SOC_UART_RX_EN)
`timescale 1ns/1ps
module tb_soc_uart;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        uart_sel = 1'b0;
   logic        uart_we = 1'b0;
   logic [3:0]  uart_addr = 4'h0;
   logic [31:0] uart_wdata = 32'd0;
   logic [31:0] uart_rdata;
   logic        uart_ready;
   logic        uart_tx;
   logic        uart_rx;
   logic        rx_loop = 1'b0;
   logic        rx_drv = 1'b1;

   int     checks = 0;
   int     passed = 0;
   int     div = 68;
   longint cyc = 0;

   typedef struct {
      logic [7:0] data;
      bit         contig;
   } exp_t;
   exp_t       tx_q[$];
   logic [7:0] rx_q[$];

   assign uart_rx = rx_loop ? uart_tx : rx_drv;

   soc_uart dut (
      .clk(clk), .rst(rst), .uart_sel(uart_sel), .uart_we(uart_we),
      .uart_addr(uart_addr), .uart_wdata(uart_wdata), .uart_rdata(uart_rdata),
      .uart_ready(uart_ready), .uart_tx(uart_tx), .uart_rx(uart_rx)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic bus(input logic we, input logic [3:0] addr, input logic [31:0] wd,
                      output logic [31:0] rd);
      uart_sel = 1'b1; uart_we = we; uart_addr = addr; uart_wdata = wd;
      @(posedge clk); #1;
      uart_sel = 1'b0; uart_we = 1'b0;
      rd = uart_rdata;
      check("bus_ready", uart_ready, 1);
   endtask

   task automatic wr(input logic [3:0] addr, input logic [31:0] data);
      logic [31:0] r;
      bus(1'b1, addr, data, r);
   endtask

   task automatic rd_chk(input string tag, input logic [3:0] addr, input logic [31:0] exp);
      logic [31:0] r;
      bus(1'b0, addr, 32'd0, r);
      check(tag, r, exp);
   endtask

   task automatic tx_send(input logic [7:0] b, input bit contig);
      exp_t e;
      e.data = b; e.contig = contig;
      tx_q.push_back(e);
      wr(4'h0, {24'd0, b});
   endtask

   task automatic drain(input string tag);
      int g = 0;
      while (tx_q.size() != 0 && g < 1500) begin @(posedge clk); g++; end
      #1;
      check(tag, tx_q.size(), 0);
      repeat (2) @(posedge clk); #1;
   endtask

   task automatic drive_rx(input logic [7:0] b, input logic stopv);
      logic [9:0] f;
      f = {stopv, b, 1'b0};
      for (int i = 0; i < 10; i++) begin
         rx_drv = f[i];
         repeat (div + 1) @(posedge clk); #1;
      end
      rx_drv = 1'b1;
      repeat (div + 1) @(posedge clk); #1;
   endtask

   // Serial monitor: captures each frame sample-by-sample and scores it against the queue
   initial begin : tx_monitor
      logic [127:0] obs, exp_pat;
      logic [7:0]   got;
      longint       t0, prev_end;
      int           d, n, b;
      exp_t         e;
      prev_end = -1;
      wait (rst === 1'b0);
      wait (rst === 1'b1);
      forever begin
         do @(negedge clk); while (uart_tx !== 1'b0);
         t0 = cyc; d = div; n = (d + 1) * 10; obs = '0;
         for (int i = 0; i < n; i++) begin
            if (i > 0) @(negedge clk);
            obs[i] = uart_tx;
         end
         for (int k = 0; k < 8; k++) got[k] = obs[(k + 1) * (d + 1) + (d + 1) / 2];
         if (tx_q.size() == 0) begin
            check("tx_unexpected_frame", 1, 0);
         end else begin
            e = tx_q.pop_front();
            exp_pat = '0;
            for (int i = 0; i < n; i++) begin
               b = i / (d + 1);
               exp_pat[i] = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : e.data[b - 1];
            end
            check("tx_frame_byte", got, e.data);
            check("tx_frame_timing", obs, exp_pat);
            if (e.contig) check("tx_no_gap", t0, prev_end);
         end
         prev_end = t0 + n;
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin : stim
      #1 rst = 1'b0;
      repeat (3) @(posedge clk); #1;
      check("reset_tx", uart_tx, 1);
      check("reset_ready", uart_ready, 0);
      check("reset_rdata", uart_rdata, 0);
      rst = 1'b1;
      @(posedge clk); #1;

      rd_chk("status_reset", 4'h4, 32'h2);
      rd_chk("bauddiv_reset", 4'h8, 32'h44);
      @(posedge clk); #1;
      check("ready_one_cycle", uart_ready, 0);
      check("rdata_idle_zero", uart_rdata, 0);
      rd_chk("txdata_read", 4'h0, 32'h0);
      rd_chk("unmapped_read", 4'h2, 32'h0);
      rd_chk("rxdata_empty", 4'hC, 32'h0);
      wr(4'h8, 32'h1);
      rd_chk("bauddiv_clamp", 4'h8, 32'h3);
      wr(4'h8, 32'hABCD0009);
      rd_chk("bauddiv_upper", 4'h8, 32'h9);
      div = 9;

      // Single frame and tx_busy duration
      tx_send(8'h55, 1'b0);
      repeat (100) @(posedge clk); #1;
      rd_chk("busy_last_cycle", 4'h4, 32'h6);
      rd_chk("busy_fall", 4'h4, 32'h2);
      drain("drain_single");

      // FIFO overflow while a frame is already on the line
      tx_send(8'h11, 1'b0);
      repeat (3) @(posedge clk); #1;
      for (int i = 0; i < 4; i++) tx_send(8'h21 + 8'(i), 1'b1);
      wr(4'h0, 32'h25);
      rd_chk("status_full_drop", 4'h4, 32'h25);
      wr(4'h4, 32'h0);
      rd_chk("w1c_zero_keeps", 4'h4, 32'h25);
      wr(4'h4, 32'h20);
      rd_chk("status_drop_clr", 4'h4, 32'h05);
      drain("drain_burst");
      rd_chk("status_after_burst", 4'h4, 32'h2);

      // Divider change mid-frame applies to the next frame only
      tx_send(8'h3C, 1'b0);
      repeat (20) @(posedge clk); #1;
      wr(4'h8, 32'h7);
      div = 7;
      rd_chk("bauddiv_mid", 4'h8, 32'h7);
      drain("drain_div9");
      tx_send(8'h5A, 1'b0);
      drain("drain_div7");

`ifdef SOC_UART_RX_EN
      rx_loop = 1'b1;
      tx_send(8'hA3, 1'b0);
      drain("drain_loop");
      repeat (5) @(posedge clk); #1;
      rx_loop = 1'b0;
      rd_chk("rx_valid_set", 4'h4, 32'h0A);
      rd_chk("rxdata_loop", 4'hC, 32'hA3);
      rd_chk("rx_valid_clear", 4'h4, 32'h2);

      drive_rx(8'h99, 1'b0);
      rd_chk("rx_frame_err", 4'h4, 32'h42);
      rd_chk("rx_ferr_no_byte", 4'hC, 32'h0);
      wr(4'h4, 32'h40);
      rd_chk("rx_ferr_clear", 4'h4, 32'h2);

      rx_drv = 1'b0;
      @(posedge clk); #1;
      rx_drv = 1'b1;
      repeat (30) @(posedge clk); #1;
      rd_chk("rx_glitch", 4'h4, 32'h2);

      for (int i = 0; i < 5; i++) begin
         if (i < 4) rx_q.push_back(8'hC1 + 8'(i * 17));
         drive_rx(8'hC1 + 8'(i * 17), 1'b1);
      end
      rd_chk("rx_overrun", 4'h4, 32'h1A);
      while (rx_q.size() != 0) rd_chk("rx_order", 4'hC, {24'd0, rx_q.pop_front()});
      rd_chk("rx_drained", 4'hC, 32'h0);
`endif

      // Reset in the middle of a frame drives the line high at once
      wr(4'h0, 32'hF0);
      repeat (15) @(posedge clk); #1;
      rst = 1'b0;
      #1;
      check("reset_midframe_tx", uart_tx, 1);
      repeat (2) @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rd_chk("status_post_reset", 4'h4, 32'h2);
      rd_chk("bauddiv_post_reset", 4'h8, 32'h44);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
